// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against long-latency unit results
// and keeps the LU destination busy scoreboard. Define WB_SKID_EN for a one-entry LU skid buffer.
module regfile_wb_scheduler #(
   parameter int MAX_LU_OUT   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        flush,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic        dec_wr,
   input  logic        dec_long,
   output logic        stall,
   output logic        lu_issue,
   input  logic        pwb_we,
   input  logic [4:0]  pwb_rd,
   input  logic [31:0] pwb_data,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        Wreg,
   output logic [4:0]  rd,
   output logic [31:0] Wdata,
   output logic [31:0] busy,
   output logic [2:0]  lu_out,
   output logic        proto_err
);

   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [2:0]      MAX_OUT    = 3'(MAX_LU_OUT);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   logic [31:0]   busy_r;
   logic [2:0]    lu_out_r;
   logic [SW-1:0] starve_r;
   logic          proto_err_r;

   logic          hazard_s;
   logic          issue_s;
   logic          lu_ready_s;
   logic          lu_write_s;
   logic          starve_inc_s;
   logic [4:0]    lu_wr_rd_s;
   logic [31:0]   lu_wr_data_s;
   logic [31:0]   busy_nxt_s;

   // Decode hazard detection against registered scoreboard state
   always_comb begin
      hazard_s = 1'b0;
      if (dec_valid) begin
         hazard_s = busy_r[dec_rs1] | busy_r[dec_rs2]
                  | (dec_wr & busy_r[dec_rd])
                  | (dec_long & (lu_out_r == MAX_OUT))
                  | (starve_r == STARVE_MAX);
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign issue_s = dec_valid & dec_long & ~hazard_s & ~flush;

`ifdef WB_SKID_EN
   logic          skid_full_r;
   logic [4:0]    skid_rd_r;
   logic [31:0]   skid_data_r;

   // LU acceptance and write source; a held skid entry always drains before a fresh LU result
   always_comb begin
      lu_ready_s   = lu_valid & ~skid_full_r & (lu_out_r != 3'd0);
      lu_write_s   = ~pwb_we & (skid_full_r | lu_ready_s);
      starve_inc_s = skid_full_r & ~lu_write_s;
      if (skid_full_r) begin
         lu_wr_rd_s   = skid_rd_r;
         lu_wr_data_s = skid_data_r;
      end else begin
         lu_wr_rd_s   = lu_rd;
         lu_wr_data_s = lu_data;
      end
   end

   // Skid buffer: captures an accepted result while PWB owns the port
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         skid_full_r <= 1'b0;
         skid_rd_r   <= 5'd0;
         skid_data_r <= 32'd0;
      end else if (lu_ready_s && pwb_we) begin
         skid_full_r <= 1'b1;
         skid_rd_r   <= lu_rd;
         skid_data_r <= lu_data;
      end else if (lu_write_s && skid_full_r) begin
         skid_full_r <= 1'b0;
      end
   end
`else
   // LU acceptance and write source: the LU only wins when PWB is idle
   always_comb begin
      lu_ready_s   = lu_valid & ~pwb_we & (lu_out_r != 3'd0);
      lu_write_s   = lu_ready_s;
      starve_inc_s = lu_valid & ~lu_ready_s & (lu_out_r != 3'd0);
      lu_wr_rd_s   = lu_rd;
      lu_wr_data_s = lu_data;
   end
`endif

   // Write-port mux with fixed priority to pipeline writeback
   always_comb begin
      Wreg  = 1'b0;
      rd    = 5'd0;
      Wdata = 32'd0;
      if (pwb_we) begin
         Wreg  = 1'b1;
         rd    = pwb_rd;
         Wdata = pwb_data;
      end else if (lu_write_s) begin
         Wreg  = 1'b1;
         rd    = lu_wr_rd_s;
         Wdata = lu_wr_data_s;
      end else begin
         Wreg  = 1'b0;
      end
   end

   // Scoreboard update: clear on LU write, then set on issue so a same-register set wins
   always_comb begin
      busy_nxt_s = busy_r;
      if (lu_write_s) begin
         busy_nxt_s[lu_wr_rd_s] = 1'b0;
      end else begin
         busy_nxt_s = busy_r;
      end
      if (issue_s && dec_wr) begin
         busy_nxt_s[dec_rd] = 1'b1;
      end else begin
         busy_nxt_s[0] = 1'b0;
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Scheduler state registers
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         busy_r      <= 32'd0;
         lu_out_r    <= 3'd0;
         starve_r    <= '0;
         proto_err_r <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         case ({issue_s, lu_write_s})
            2'b10:   lu_out_r <= lu_out_r + 3'd1;
            2'b01:   lu_out_r <= lu_out_r - 3'd1;
            default: lu_out_r <= lu_out_r;
         endcase
         if (lu_write_s) begin
            starve_r <= '0;
         end else if (starve_inc_s && (starve_r != STARVE_MAX)) begin
            starve_r <= starve_r + SW'(1);
         end
         if (lu_valid && (lu_out_r == 3'd0)) begin
            proto_err_r <= 1'b1;
         end
      end
   end

   assign stall     = hazard_s & ~flush;
   assign lu_issue  = issue_s;
   assign lu_ready  = lu_ready_s;
   assign busy      = busy_r;
   assign lu_out    = lu_out_r;
   assign proto_err = proto_err_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler (default build): expected write-port traffic is queued
// by the stimulus and popped by a negedge monitor, which also checks per-cycle status expectations.
module tb_regfile_wb_scheduler;

   logic        Clock = 1'b0;
   logic        nReset;
   logic        flush, dec_valid, dec_wr, dec_long;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        stall, lu_issue;
   logic        pwb_we;
   logic [4:0]  pwb_rd;
   logic [31:0] pwb_data;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready, Wreg;
   logic [4:0]  rd;
   logic [31:0] Wdata, busy;
   logic [2:0]  lu_out;
   logic        proto_err;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t         wq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [6:0]  mask = 7'd0;
   logic        e_stall, e_issue, e_ready, e_wreg, e_perr;
   logic [31:0] e_busy;
   logic [2:0]  e_out;
   logic        done_chk = 1'b0;

   regfile_wb_scheduler dut (
      .Clock(Clock), .nReset(nReset), .flush(flush), .dec_valid(dec_valid),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_wr(dec_wr),
      .dec_long(dec_long), .stall(stall), .lu_issue(lu_issue), .pwb_we(pwb_we),
      .pwb_rd(pwb_rd), .pwb_data(pwb_data), .lu_valid(lu_valid), .lu_rd(lu_rd),
      .lu_data(lu_data), .lu_ready(lu_ready), .Wreg(Wreg), .rd(rd), .Wdata(Wdata),
      .busy(busy), .lu_out(lu_out), .proto_err(proto_err)
   );

   always #5 Clock = ~Clock;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: status checks and write-port scoreboard
   always @(negedge Clock) begin : monitor
      wr_t e;
      if (mask[0]) cmp("stall", 32'(stall), 32'(e_stall));
      if (mask[1]) cmp("lu_issue", 32'(lu_issue), 32'(e_issue));
      if (mask[2]) cmp("lu_ready", 32'(lu_ready), 32'(e_ready));
      if (mask[3]) cmp("Wreg", 32'(Wreg), 32'(e_wreg));
      if (mask[4]) cmp("busy", busy, e_busy);
      if (mask[5]) cmp("lu_out", 32'(lu_out), 32'(e_out));
      if (mask[6]) cmp("proto_err", 32'(proto_err), 32'(e_perr));
      if (nReset && Wreg) begin
         if (wq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wport_unexpected: got write rd=%0d data=%h required no write", rd, Wdata);
         end else begin
            e = wq.pop_front();
            cmp("wport_rd", 32'(rd), 32'(e.rd));
            cmp("wport_data", Wdata, e.data);
         end
      end
      if (done_chk) cmp("wq_drained", 32'(wq.size()), 32'd0);
   end

   task automatic idle_inputs();
      nReset = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_wr = 1'b0; dec_long = 1'b0;
      dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
      pwb_we = 1'b0; pwb_rd = 5'd0; pwb_data = 32'd0;
      lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
   endtask

   task automatic cyc();
      @(posedge Clock);
      #1;
      mask = 7'd0;
      idle_inputs();
   endtask

   task automatic dec(input logic l, input logic w, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2);
      dec_valid = 1'b1; dec_long = l; dec_wr = w; dec_rd = d; dec_rs1 = s1; dec_rs2 = s2;
   endtask

   task automatic exp_wr(input logic [4:0] r, input logic [31:0] dt);
      wr_t e;
      e.rd = r;
      e.data = dt;
      wq.push_back(e);
   endtask

   task automatic pwb(input logic [4:0] r, input logic [31:0] dt);
      pwb_we = 1'b1; pwb_rd = r; pwb_data = dt;
      exp_wr(r, dt);
   endtask

   task automatic lu(input logic [4:0] r, input logic [31:0] dt);
      lu_valid = 1'b1; lu_rd = r; lu_data = dt;
   endtask

   task automatic exp_dec(input logic st, input logic is);
      e_stall = st; e_issue = is; mask[0] = 1'b1; mask[1] = 1'b1;
   endtask

   task automatic exp_port(input logic rdy, input logic wr);
      e_ready = rdy; e_wreg = wr; mask[2] = 1'b1; mask[3] = 1'b1;
   endtask

   task automatic exp_st(input logic [31:0] b, input logic [2:0] o);
      e_busy = b; e_out = o; mask[4] = 1'b1; mask[5] = 1'b1;
   endtask

   task automatic exp_perr(input logic p);
      e_perr = p; mask[6] = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] b;
      idle_inputs();
      nReset = 1'b0;
      // reset held over two edges with random activity on every input
      for (int i = 0; i < 2; i++) begin
         flush = 1'($urandom); dec_valid = 1'($urandom); dec_wr = 1'($urandom);
         dec_long = 1'($urandom); dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom);
         dec_rd = 5'($urandom); pwb_we = 1'($urandom); pwb_rd = 5'($urandom);
         pwb_data = $urandom; lu_valid = 1'($urandom); lu_rd = 5'($urandom); lu_data = $urandom;
         @(posedge Clock);
         #1;
      end
      idle_inputs();
      exp_st(32'd0, 3'd0); exp_port(1'b0, 1'b0); exp_dec(1'b0, 1'b0); exp_perr(1'b0);

      // RAW hazard on x5
      cyc(); dec(1'b1, 1'b1, 5'd5, 5'd0, 5'd0); exp_dec(1'b0, 1'b1); exp_st(32'd0, 3'd0);
      cyc(); dec(1'b0, 1'b1, 5'd6, 5'd5, 5'd0); exp_dec(1'b1, 1'b0); exp_st(32'h20, 3'd1);
      cyc(); dec(1'b0, 1'b1, 5'd6, 5'd5, 5'd0); lu(5'd5, 32'hDEADBEEF);
      exp_wr(5'd5, 32'hDEADBEEF); exp_dec(1'b1, 1'b0); exp_port(1'b1, 1'b1);
      cyc(); dec(1'b0, 1'b1, 5'd6, 5'd5, 5'd0); exp_dec(1'b0, 1'b0); exp_st(32'd0, 3'd0);

      // port conflict: PWB wins, LU goes next cycle
      cyc(); dec(1'b1, 1'b1, 5'd7, 5'd0, 5'd0); exp_dec(1'b0, 1'b1);
      cyc(); pwb(5'd3, 32'h33333333); lu(5'd7, 32'h77777777);
      exp_port(1'b0, 1'b1); exp_st(32'h80, 3'd1);
      cyc(); lu(5'd7, 32'h77777777); exp_wr(5'd7, 32'h77777777);
      exp_port(1'b1, 1'b1); exp_st(32'h80, 3'd1);
      cyc(); exp_st(32'd0, 3'd0); exp_port(1'b0, 1'b0);

      // capacity: four outstanding, fifth stalls until a retire
      b = 32'd0;
      for (int i = 1; i <= 4; i++) begin
         cyc(); dec(1'b1, 1'b1, 5'(i), 5'd0, 5'd0); exp_dec(1'b0, 1'b1); exp_st(b, 3'(i - 1));
         b[i] = 1'b1;
      end
      cyc(); dec(1'b1, 1'b1, 5'd8, 5'd0, 5'd0); exp_dec(1'b1, 1'b0); exp_st(32'h1E, 3'd4);
      cyc(); dec(1'b1, 1'b1, 5'd8, 5'd0, 5'd0); lu(5'd1, 32'h11111111);
      exp_wr(5'd1, 32'h11111111); exp_dec(1'b1, 1'b0); exp_port(1'b1, 1'b1);
      cyc(); dec(1'b1, 1'b1, 5'd8, 5'd0, 5'd0); exp_dec(1'b0, 1'b1); exp_st(32'h1C, 3'd3);
      cyc(); exp_st(32'h11C, 3'd4);
      for (int k = 2; k <= 4; k++) begin
         cyc(); lu(5'(k), 32'(k) * 32'h01010101); exp_wr(5'(k), 32'(k) * 32'h01010101);
         exp_port(1'b1, 1'b1);
      end
      cyc(); exp_st(32'h100, 3'd1);

      // starvation: eight denied cycles, then decode throttled until the LU writes
      for (int k = 0; k < 8; k++) begin
         cyc(); dec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); pwb(5'(10 + k), 32'(k));
         lu(5'd8, 32'h88888888); exp_dec(1'b0, 1'b0); exp_port(1'b0, 1'b1);
      end
      cyc(); dec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); pwb(5'd20, 32'h20202020);
      lu(5'd8, 32'h88888888); exp_dec(1'b1, 1'b0); exp_port(1'b0, 1'b1);
      cyc(); dec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); lu(5'd8, 32'h88888888);
      exp_wr(5'd8, 32'h88888888); exp_dec(1'b1, 1'b0); exp_port(1'b1, 1'b1);
      cyc(); dec(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); exp_dec(1'b0, 1'b0); exp_st(32'd0, 3'd0);

      // flush kills a long op
      cyc(); dec(1'b1, 1'b1, 5'd9, 5'd0, 5'd0); flush = 1'b1; exp_dec(1'b0, 1'b0);
      cyc(); exp_st(32'd0, 3'd0);
      // long op to x0 is counted but never marked
      cyc(); dec(1'b1, 1'b1, 5'd0, 5'd0, 5'd0); exp_dec(1'b0, 1'b1);
      cyc(); exp_st(32'd0, 3'd1);
      // simultaneous issue and retire keeps the count
      cyc(); dec(1'b1, 1'b1, 5'd13, 5'd0, 5'd0); lu(5'd0, 32'hCAFEF00D);
      exp_wr(5'd0, 32'hCAFEF00D); exp_dec(1'b0, 1'b1); exp_port(1'b1, 1'b1);
      cyc(); exp_st(32'h2000, 3'd1);
      cyc(); lu(5'd13, 32'h0D0D0D0D); exp_wr(5'd13, 32'h0D0D0D0D); exp_port(1'b1, 1'b1);
      // LU result with nothing outstanding
      cyc(); lu(5'd5, 32'h55555555); exp_port(1'b0, 1'b0); exp_perr(1'b0); exp_st(32'd0, 3'd0);
      cyc(); exp_perr(1'b1); exp_port(1'b0, 1'b0); exp_st(32'd0, 3'd0);
      cyc(); exp_perr(1'b1);
      // sticky flag cleared only by reset
      cyc(); nReset = 1'b0;
      cyc(); exp_perr(1'b0); exp_st(32'd0, 3'd0); exp_port(1'b0, 1'b0);

      cyc();
      done_chk = 1'b1;
      @(negedge Clock);
      #1;
      done_chk = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file and shares it between two sources: in-order pipeline writeback (PWB) and an out-of-band long-latency unit (LU, e.g. divider or load miss).
- Keeps a per-register busy scoreboard for LU destinations and stalls decode on RAW/WAW hazards against outstanding LU results.
- Sits between decode, the LU and the register file: drives its Wreg/rd/Wdata inputs.

Parameters:
- MAX_LU_OUT, 4, maximum outstanding LU operations (1..7).
- STARVE_LIMIT, 8, consecutive cycles an LU result may be denied the write port before decode is throttled.

Ports:
- Clock  in  1  system clock
- nReset  in  1  synchronous active-low reset
- flush  in  1  kill the instruction currently in decode
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1  in  5  source register 1
- dec_rs2  in  5  source register 2
- dec_rd  in  5  destination register
- dec_wr  in  1  instruction writes dec_rd
- dec_long  in  1  instruction executes on the LU
- stall  out  1  hold decode
- lu_issue  out  1  launch LU op this cycle
- pwb_we  in  1  pipeline writeback enable
- pwb_rd  in  5  pipeline writeback register
- pwb_data  in  32  pipeline writeback data
- lu_valid  in  1  LU result available
- lu_rd  in  5  LU result register
- lu_data  in  32  LU result data
- lu_ready  out  1  LU result accepted this cycle
- Wreg  out  1  register file write enable
- rd  out  5  register file write address
- Wdata  out  32  register file write data
- busy  out  32  scoreboard bitmap
- lu_out  out  3  outstanding LU count
- proto_err  out  1  sticky: LU result with lu_out==0

Behaviour:
- Reset (nReset low at a rising edge): busy=0, lu_out=0, starve counter=0, proto_err=0, skid empty. Combinational outputs follow from this state.
- busy[0] is always 0. Register 0 never stalls and is never marked.
- hazard is asserted when dec_valid and any of the following hold, all evaluated on registered busy:
  - RAW: busy[dec_rs1] or busy[dec_rs2]
  - WAW: dec_wr and busy[dec_rd]
  - capacity: dec_long and lu_out==MAX_LU_OUT
  - starve: starve counter at STARVE_LIMIT
- stall = hazard and not flush. flush forces stall=0 and lu_issue=0 that cycle.
- lu_issue = dec_valid and dec_long and not hazard and not flush (combinational).
  - At the clock edge: lu_out increments; busy[dec_rd] is set if dec_wr and dec_rd!=0.
- Write-port arbitration is fixed priority to PWB. Outputs are combinational.
  - pwb_we=1: Wreg=1, rd=pwb_rd, Wdata=pwb_data.
  - Otherwise, if an LU result is pending: Wreg=1, rd/Wdata from the LU result; busy[lu_rd] is cleared and lu_out decrements at the edge.
  - Otherwise Wreg=0, rd=0, Wdata=0.
- Base lu_ready = lu_valid and not pwb_we and lu_out!=0 (the LU holds lu_rd/lu_data until lu_ready).
- Starve counter:
  - Increments each cycle lu_valid=1 and lu_ready=0 with lu_out!=0, saturating at STARVE_LIMIT.
  - Clears to 0 on any LU write.
  - At the limit it throttles decode until the pipeline drains and PWB goes idle.
- Simultaneous issue and retire: lu_out stays unchanged. If set and clear target the same register, the set wins.
- lu_valid with lu_out==0: the result is not accepted, proto_err sets (cleared only by reset), no write occurs.
- lu_out never exceeds MAX_LU_OUT and never underflows.
- Reset mid-operation discards all scoreboard state. The LU is reset on the same nReset.

Optional Feature:
- WB_SKID_EN defined: a one-entry skid buffer between the LU and the write port.
  - lu_ready = lu_valid and not skid_full and lu_out!=0, so the LU is accepted even while PWB owns the port.
  - An accepted result goes straight to the port if PWB is idle, otherwise into the skid.
  - The skid drains at the first PWB-idle cycle, before any new LU result.
  - The scoreboard is cleared and lu_out decremented only when the data is written to the register file, not on acceptance.
  - Starve counting uses skid occupancy instead of lu_valid.
- WB_SKID_EN undefined: no skid; base lu_ready rule applies.

Test Plan:
- Reset: hold nReset=0 for 2 edges with random inputs -> busy=0, lu_out=0, Wreg=0, stall=0, proto_err=0.
- RAW stall: issue long op with rd=5 (lu_issue=1), next cycle decode rs1=5 -> stall=1 until LU writes x5=0xDEADBEEF, busy[5] clears at that edge, stall=0 the following cycle.
- Port conflict: pwb_we=1 rd=3 and lu_valid=1 rd=7 in the same cycle -> rd=3, lu_ready=0. Next cycle PWB idle -> rd=7, lu_ready=1, lu_out decrements.
- Capacity: issue 4 long ops to x1..x4 -> lu_out=4, 5th long op stalls. One LU retire -> 5th issues the cycle after.
- Starvation: lu_valid held with pwb_we=1 for 8 cycles -> stall=1 on cycle 9 regardless of operands. After PWB idle, LU written and stall releases.
- Flush and x0: flush with dec_long=1 -> lu_issue=0, lu_out unchanged. Long op with rd=0 -> busy stays 0. lu_valid with lu_out=0 -> proto_err=1, Wreg=0.
